// File: rtl/pacman_pkg.sv
// Shared types, point values and arithmetic helpers for the Pacman scoring datapath.
package pacman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DEATH = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } game_state_t;

  localparam logic [15:0] PTS_PELLET     = 16'd10;
  localparam logic [15:0] PTS_POWER      = 16'd50;
  localparam logic [15:0] PTS_GHOST_BASE = 16'd200;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pacman_fright_timer.sv
// Loadable down-counter: active while counting, one-cycle pulse when it runs out.
// Also intended for the ghost scatter/chase timer.
module pacman_fright_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_active,
  output logic             o_expired_pulse
);

  localparam logic [WIDTH-1:0] TC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_active;
  logic             r_expired;

  // Clear beats load so a forced exit can never leave the timer running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_active  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (i_clear) begin
        r_count  <= '0;
        r_active <= 1'b0;
      end else if (i_load) begin
        r_count  <= i_load_value;
        r_active <= (i_load_value != '0);
      end else if (r_active) begin
        r_count <= r_count - TC_ONE;
        if (r_count == TC_ONE) begin
          r_active  <= 1'b0;
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign o_active        = r_active;
  assign o_expired_pulse = r_expired;

endmodule

// File: rtl/pacman_score_keeper.sv
// Game-progress and scoring controller: pellet/power maps, score, lives,
// frightened mode with ghost-eat chain, and held win/lose flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold last game's values
// ST_PLAY  | consuming pellets, scoring, evaluating ghost collisions
// ST_DEATH | post-death pause, frightened cleared, respawn on expiry
// ST_WIN   | all pellets eaten; win held until ack
// ST_LOSE  | out of lives; lose held until ack
module pacman_score_keeper
  import pacman_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS    = 4,
  parameter int unsigned COLS          = 28,
  parameter int unsigned ROWS          = 31,
  parameter int unsigned START_LIVES   = 3,
  parameter logic [23:0] FRIGHT_CYCLES = 24'd6_000_000,
  parameter logic [23:0] DEATH_CYCLES  = 24'd3_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_ack,
  input  logic [COLS*ROWS-1:0]    i_pellet_init,
  input  logic [COLS*ROWS-1:0]    i_power_init,
  input  logic [$clog2(COLS)-1:0] i_tile_x,
  input  logic [$clog2(ROWS)-1:0] i_tile_y,
  input  logic                    i_tile_valid,
  input  logic [NUM_GHOSTS-1:0]   i_ghost_hit,
  output logic [15:0]             o_score,
  output logic [2:0]              o_lives,
  output logic [9:0]              o_pellets_left,
  output logic                    o_frightened,
  output logic [NUM_GHOSTS-1:0]   o_ghost_eaten,
  output logic                    o_respawn,
  output logic                    o_win,
  output logic                    o_lose
);

  localparam int unsigned TILES      = COLS * ROWS;
  localparam int unsigned IW         = $clog2(TILES);
  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [23:0] DEATH_LOAD = (DEATH_CYCLES == 24'd0) ? 24'd1 : DEATH_CYCLES;

  game_state_t            r_state, w_state_next;
  logic [15:0]            r_score, w_score_next;
  logic [2:0]             r_lives, w_lives_next;
  logic [9:0]             r_left, w_left_next;
  logic [TILES-1:0]       r_pellet_map, w_pellet_map_next;
  logic [TILES-1:0]       r_power_map, w_power_map_next;
  logic [1:0]             r_chain, w_chain_next;
  logic [NUM_GHOSTS-1:0]  r_ghost_prev;
  logic [NUM_GHOSTS-1:0]  r_eaten, w_eaten_next;
  logic                   r_respawn, w_respawn_next;
  logic [23:0]            r_death_cnt, w_death_next;

  logic                   w_fright;
  logic                   w_fright_expired;
  logic                   w_fright_load;
  logic                   w_fright_clear;
  logic                   w_in_range;
  logic [IW-1:0]          w_idx;
  logic [9:0]             w_init_count;

  assign w_in_range = (32'(i_tile_x) < COLS) && (32'(i_tile_y) < ROWS);
  assign w_idx      = IW'(i_tile_y) * IW'(COLS) + IW'(i_tile_x);

  // A tile flagged in both maps counts once and is eaten as a power pellet.
  always_comb begin
    w_init_count = '0;
    for (int i = 0; i < TILES; i++) begin
      w_init_count = w_init_count + 10'(i_pellet_init[i] | i_power_init[i]);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_score_next      = r_score;
    w_lives_next      = r_lives;
    w_left_next       = r_left;
    w_pellet_map_next = r_pellet_map;
    w_power_map_next  = r_power_map;
    w_chain_next      = r_chain;
    w_eaten_next      = '0;
    w_respawn_next    = 1'b0;
    w_death_next      = r_death_cnt;
    w_fright_load     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_pellet_map_next = i_pellet_init;
          w_power_map_next  = i_power_init;
          w_left_next       = w_init_count;
          w_score_next      = '0;
          w_lives_next      = LIVES_INIT;
          w_state_next      = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (i_tile_valid && w_in_range && (r_pellet_map[w_idx] || r_power_map[w_idx])) begin
          w_pellet_map_next[w_idx] = 1'b0;
          w_power_map_next[w_idx]  = 1'b0;
          if (r_left != '0) w_left_next = r_left - 10'd1;
          if (r_power_map[w_idx]) begin
            w_score_next  = sat_add16(w_score_next, PTS_POWER);
            w_fright_load = 1'b1;
          end else begin
            w_score_next = sat_add16(w_score_next, PTS_PELLET);
          end
        end
        // Chain index saturates at 3, so every ghost past the fourth is worth 1600.
        for (int i = 0; i < NUM_GHOSTS; i++) begin
          if (w_fright && i_ghost_hit[i] && !r_ghost_prev[i]) begin
            w_eaten_next[i] = 1'b1;
            w_score_next    = sat_add16(w_score_next, PTS_GHOST_BASE << w_chain_next);
            if (w_chain_next != 2'd3) w_chain_next = w_chain_next + 2'd1;
          end
        end
        if (w_left_next == '0) begin
          w_state_next = ST_WIN;
        end else if (!w_fright && (|i_ghost_hit)) begin
          if (r_lives != '0) w_lives_next = r_lives - 3'd1;
          w_state_next = (w_lives_next == '0) ? ST_LOSE : ST_DEATH;
          w_death_next = DEATH_LOAD;
        end
      end
      ST_DEATH: begin
        if (r_death_cnt <= 24'd1) begin
          w_state_next   = ST_PLAY;
          w_respawn_next = 1'b1;
        end else begin
          w_death_next = r_death_cnt - 24'd1;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (i_ack) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_fright_clear = (r_state != ST_PLAY) || (w_state_next != ST_PLAY);

  pacman_fright_timer #(
    .WIDTH(24)
  ) u_fright_timer (
    .clk            (clk),
    .reset          (reset),
    .i_clear        (w_fright_clear),
    .i_load         (w_fright_load),
    .i_load_value   (FRIGHT_CYCLES),
    .o_active       (w_fright),
    .o_expired_pulse(w_fright_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_lives      <= '0;
      r_left       <= '0;
      r_pellet_map <= '0;
      r_power_map  <= '0;
      r_chain      <= '0;
      r_ghost_prev <= '0;
      r_eaten      <= '0;
      r_respawn    <= 1'b0;
      r_death_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_score      <= w_score_next;
      r_lives      <= w_lives_next;
      r_left       <= w_left_next;
      r_pellet_map <= w_pellet_map_next;
      r_power_map  <= w_power_map_next;
      r_chain      <= (w_fright_clear || w_fright_expired) ? 2'd0 : w_chain_next;
      r_ghost_prev <= i_ghost_hit;
      r_eaten      <= w_eaten_next;
      r_respawn    <= w_respawn_next;
      r_death_cnt  <= w_death_next;
    end
  end

  assign o_score        = r_score;
  assign o_lives        = r_lives;
  assign o_pellets_left = r_left;
  assign o_frightened   = w_fright;
  assign o_ghost_eaten  = r_eaten;
  assign o_respawn      = r_respawn;
  assign o_win          = (r_state == ST_WIN);
  assign o_lose         = (r_state == ST_LOSE);

endmodule

// File: doc/pacman_score_keeper.md
# pacman_score_keeper

Parametrised game-progress and scoring controller for the Pacman datapath. It sits between the movement/collision logic and the display/HUD. It owns the pellet and power-pellet maps at tile granularity, awards points, and runs a frightened-mode timer with a ghost-eat chain bonus. It tracks lives across deaths and raises level-clear (win) or game-over (lose) flags that are held until acknowledged.

## Interface
Parameters:
- NUM_GHOSTS, 4, number of ghost collision channels (1-8)
- COLS, 28, maze width in tiles
- ROWS, 31, maze height in tiles
- START_LIVES, 3, lives at game start (1-7)
- FRIGHT_CYCLES, 24'd6_000_000, frightened-mode duration in clk cycles
- DEATH_CYCLES, 24'd3_000_000, death pause in clk cycles before respawn

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  level; begins a game from IDLE
- ack  in  1  level; clears WIN/LOSE back to IDLE
- pellet_init  in  COLS*ROWS  pellet layout; bit index = y*COLS+x
- power_init  in  COLS*ROWS  power-pellet layout; bits disjoint from pellet_init
- tile_x  in  $clog2(COLS)  Pacman tile column
- tile_y  in  $clog2(ROWS)  Pacman tile row
- tile_valid  in  1  Pacman centred in its tile; gates pellet consumption
- ghost_hit  in  NUM_GHOSTS  per-ghost overlap with Pacman
- score  out  16  running score
- lives  out  3  remaining lives
- pellets_left  out  10  combined pellet + power-pellet count
- frightened  out  1  frightened mode active
- ghost_eaten  out  NUM_GHOSTS  1-cycle pulse per ghost eaten
- respawn  out  1  1-cycle pulse when DEATH ends
- win  out  1  held high in WIN
- lose  out  1  held high in LOSE

## Operation
- States: IDLE, PLAY, DEATH, WIN, LOSE.
- IDLE:
  - start=1 loads both maps from the init vectors, sets pellets_left to the popcount of the loaded maps, score=0, lives=START_LIVES, then enters PLAY.
  - ack is ignored.
- PLAY, when tile_valid=1 and the addressed map bit is set:
  - The bit is cleared and pellets_left is decremented.
  - A pellet adds 10 points.
  - A power pellet adds 50 points, loads the fright timer to FRIGHT_CYCLES, and sets frightened=1.
  - A power pellet eaten while already frightened reloads the timer but does not reset the eat chain.
- Ghost hits in PLAY are evaluated using frightened as registered at the start of the cycle:
  - Frightened: each hit ghost pulses ghost_eaten[i] and awards 200, 400, 800, then 1600 for every further ghost. Simultaneous hits are awarded in ascending index order. The chain resets when frightened falls.
  - Not frightened, any hit: lives decrements. If the result is 0, go to LOSE; otherwise go to DEATH.
- Priority within one PLAY cycle:
  - The pellet is consumed and scored first.
  - If pellets_left reaches 0, go to WIN; this overrides a death in the same cycle.
- DEATH:
  - Counts DEATH_CYCLES and clears frightened.
  - The maps and score are kept.
  - On expiry, pulse respawn and return to PLAY.
- WIN/LOSE: win or lose is held; ack=1 returns to IDLE. start is ignored in all states other than IDLE.
- Arithmetic: score saturates at 16'hFFFF, with no wrap. pellets_left never underflows.

## Timing
- Reset values:
  - State IDLE.
  - score=0, lives=0, pellets_left=0, maps all zero.
  - frightened=0, ghost_eaten=0, respawn=0, win=0, lose=0.
- Reset mid-game aborts immediately to these values.
- Latency: inputs are sampled at edge N; score, pellets_left, frightened, ghost_eaten and the state change are all visible after edge N. This is 1-cycle registered latency with no combinational input-to-output paths.
- The fright timer decrements once per cycle while frightened. frightened falls on the cycle the timer reaches 0.
- A held tile_valid on an already-consumed tile awards nothing. The award is therefore once per pellet even if Pacman stays on the tile.
- A ghost that stays overlapping after being eaten is not re-awarded. The ghost_hit[i] edge is tracked per ghost.
- ack and start are level-sensitive and checked only in their accepting states.

## Structure
- Shared package pacman_pkg holds:
  - the game_state_t enum;
  - the point constants PTS_PELLET=10, PTS_POWER=50, PTS_GHOST_BASE=200;
  - the saturating-add function.
- Sub-module pacman_fright_timer:
  - Ports: load, load_value, active, expired_pulse.
  - Reused later for the ghost scatter/chase timer.
- The maps are flat COLS*ROWS registers, indexed y*COLS+x.

## Test plan
- Start with 3 pellets at (1,1),(2,1),(3,1) and no power pellets. Visit all three with tile_valid=1 → score=30 and win=1 on the cycle after the third; ack → IDLE.
- Eat a power pellet, then assert ghost_hit=4'b0011 in the same cycle, then ghost_hit=4'b1100 → score=50+200+400+800+1600=3050, frightened=1, ghost_eaten pulses.
- No fright, START_LIVES=2: ghost_hit[0]=1 → lives=1, DEATH for DEATH_CYCLES, respawn pulse; a second hit → lives=0, lose=1.
- Last pellet consumed in the same cycle as a non-frightened ghost hit → win=1, lives unchanged.
- FRIGHT_CYCLES=10: a second power pellet at cycle 5 → frightened stays high until cycle 15, and the chain continues at 400.
- Assert reset mid-PLAY with score 1230 → all outputs return to their reset values asynchronously.
